uart_rx_fifo_param: RTL and testbench
=====================================

# uart_rx_fifo_param

Parametrised 8-N-1-style serial receiver with a configurable data width, oversampling ratio, majority-vote bit sampling, error reporting and an integrated receive FIFO. It is the receive-side successor to the fixed 8-bit, 4x-oversampled receiver. It sits between a pad-level serial input and any byte consumer, such as a packet deframer or command parser. The consumer drains bytes through a valid/ready handshake instead of catching a single-cycle strobe.

## Interface
- `DATA_BITS`, default 8: payload bits per frame. Legal range 5..9.
- `OVERSAMPLE`, default 4: `baud_tick` pulses per bit period. Must be even and at least 4.
- `FIFO_DEPTH`, default 16: receive FIFO entries. Must be a power of two, at least 2.
- `PARITY_ODD`, default 0: parity sense when parity is compiled in. 0 = even, 1 = odd.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `baud_tick`, input, 1: single-cycle enable at OVERSAMPLE × baud rate.
- `serial`, input, 1: asynchronous RX line. Idle level is high.
- `data`, output, DATA_BITS: head-of-FIFO byte, LSB first on the wire. Valid while `data_valid` is high.
- `data_valid`, output, 1: FIFO is not empty.
- `data_ready`, input, 1: consumer pop request. A pop occurs on a cycle where `data_valid && data_ready`.
- `frame_error`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `parity_error`, output, 1: one-cycle pulse when parity mismatches. Tied to 0 when parity is compiled out.
- `overflow`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fill`, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- **Input synchronisation.** `serial` passes through a two-flop synchroniser. Reset value of both flops is 1.
- **Phase counter.** Advances only on `baud_tick`. MID = OVERSAMPLE/2.
- **Bit sampling.** Each bit value is the majority of the synchronised samples taken at ticks MID-1, MID and MID+1 of that bit period.
- **IDLE.** A low synchronised sample on a tick starts the phase counter at 0 and moves to START.
- **START.** At phase MID+1:
  - voted 1 means a glitch: return to IDLE, no output;
  - voted 0: move to DATA and reset the bit index.
- **DATA.** One voted bit per bit period, shifted in LSB first. After DATA_BITS bits, move to PARITY (if compiled in) or to STOP.
- **PARITY.** Compares the voted bit against the XOR of the data bits, XORed with PARITY_ODD. Records any mismatch, then moves to STOP.
- **STOP.** Evaluated at phase MID+1. The FSM returns to IDLE immediately so the next start edge can land in the second half of the stop bit.
  - Voted 0: pulse `frame_error` and do not push.
  - Otherwise, if a parity mismatch was recorded: pulse `parity_error` and do not push.
  - Otherwise: push the byte to the FIFO.
  - Both errors present: only `frame_error` pulses.
- **FIFO.** Show-ahead; `data` reflects the head entry combinationally from the registered read pointer.
- **Push into a full FIFO.**
  - Without a simultaneous pop: the byte is dropped and `overflow` pulses.
  - With a simultaneous pop in the same cycle: the push is accepted and `fill` is unchanged.
- **Pop on empty.** Impossible by construction, since `data_valid` is 0 when empty.
- **Pointers.** Read and write pointers carry one extra wrap bit. Full is detected as equal indices with differing wrap bits.

## Timing
- **Reset values.** `data_valid`=0, `fill`=0, all error pulses 0, FSM in IDLE, pointers 0, `data` = 0 (RAM reset or mux gated).
- **Reset mid-frame.** The partial frame is discarded; no push and no error pulse.
- **Push latency.** The push, `frame_error` or `parity_error` happens on the clk cycle immediately after the tick at which the STOP vote completes.
- **Visibility.** `data_valid` rises, and `fill` increments, on the cycle after the push.
- **Pop.** `fill` decrements and `data` advances on the cycle after a pop.
- **Back-to-back pops.** A consumer holding `data_ready` high drains one entry per clk.
- **Throughput.** One frame per (1 + DATA_BITS + P + 1) × OVERSAMPLE ticks sustained, where P is 1 with parity and 0 without.

## Configuration
- **Macro: `UART_RX_PARITY_EN`.**
- **Defined.** The PARITY state exists, every frame carries one parity bit, and `parity_error` is live.
- **Undefined.** There is no PARITY state and frames are start + DATA_BITS + stop. `parity_error` is tied to 0 and the PARITY_ODD parameter is ignored.

## Test plan
- **Basic receive.** OVERSAMPLE=4, DATA_BITS=8, no parity. Send 0x55 then 0xA3 at exactly 4 ticks per bit, with `data_ready`=0.
  - Required: `fill` reaches 2 and `data`=0x55.
  - Then pop: `data`=0xA3 and `fill`=1.
- **Parity.** `UART_RX_PARITY_EN` defined, PARITY_ODD=0. Send 0xA5 with parity bit 0 → byte pushed. Send 0xA5 with parity bit 1 → `parity_error` pulses once and `fill` is unchanged.
- **Framing.** Send 0x3C with the stop bit held low → `frame_error` pulses once and there is no push. A following good 0x3C is received correctly.
- **Overflow.** FIFO_DEPTH=16. Send 17 bytes 0x00..0x10 without popping.
  - Required: `overflow` pulses on the 17th byte and `fill`=16.
  - Drain: output is 0x00..0x0F in order.
- **Full with simultaneous pop.** FIFO full, with a pop timed on the push cycle → `overflow` stays 0, `fill` stays 16, and the new byte appears last.
- **Glitch and reset.**
  - A 1-tick low pulse on an idle line → no push and no error.
  - Assert `reset` for 1 clk at DATA bit 4 of a frame → no push. The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo_param
//  Purpose  : Parametrised start/data/[parity]/stop serial receiver with
//             majority-vote bit sampling, error pulses and a show-ahead
//             receive FIFO drained through a valid/ready handshake.
//  Options  : define UART_RX_PARITY_EN to add one parity bit per frame and
//             enable parity_error (sense chosen by PARITY_ODD).
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        baud_tick,
    input  logic                        serial,
    output logic [DATA_BITS-1:0]        data,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        frame_error,
    output logic                        parity_error,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fill
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [PW-1:0] c_mid_m1 = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] c_mid    = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] c_mid_p1 = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [PW-1:0] c_ph_max = PW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_last   = BW'(DATA_BITS - 1);

    // Elaboration-time sanity checks on the parameter set.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_rx_fifo_param: DATA_BITS must be 5..9");
    end
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_chk_oversample
        $error("uart_rx_fifo_param: OVERSAMPLE must be even and >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_rx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_parity_odd
        $error("uart_rx_fifo_param: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic                 sync1_q, sync2_q;
    state_t               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 s0_q, s0_d;       // sample at MID-1
    logic                 s1_q, s1_d;       // sample at MID
    logic                 push_q, push_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    localparam logic c_par_odd = (PARITY_ODD != 0);
    logic                 perr_q, perr_d;   // mismatch recorded for this frame
    logic                 pe_q, pe_d;
`endif

    logic w_vote;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial;
            sync2_q <= sync1_q;
        end
    end

    // Majority of the two stored samples and the current one (used at MID+1).
    assign w_vote = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            pe_q    <= pe_d;
`endif
        end
    end

    // Next-state logic; everything advances only on baud_tick.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
        pe_d    = 1'b0;
`endif
        if (baud_tick) begin
            if (state_q == ST_IDLE) begin
                // The detecting tick is phase 0, so the next tick is phase 1.
                if (!sync2_q) begin
                    state_d = ST_START;
                    phase_d = PW'(1);
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end else begin
                phase_d = (phase_q == c_ph_max) ? '0 : phase_q + PW'(1);
                if (phase_q == c_mid_m1) begin
                    s0_d = sync2_q;
                end
                if (phase_q == c_mid) begin
                    s1_d = sync2_q;
                end
                if (phase_q == c_mid_p1) begin
                    case (state_q)
                        ST_START: begin
                            if (w_vote) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_DATA;
                                bit_d   = '0;
                            end
                        end
                        ST_DATA: begin
                            shreg_d = {w_vote, shreg_q[DATA_BITS-1:1]};
                            if (bit_q == c_last) begin
`ifdef UART_RX_PARITY_EN
                                state_d = ST_PARITY;
`else
                                state_d = ST_STOP;
`endif
                            end else begin
                                bit_d = bit_q + BW'(1);
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        ST_PARITY: begin
                            perr_d  = w_vote ^ (^shreg_q) ^ c_par_odd;
                            state_d = ST_STOP;
                        end
`endif
                        ST_STOP: begin
                            // Back to IDLE now so a start edge in the second
                            // half of the stop bit is caught.
                            state_d = ST_IDLE;
                            if (!w_vote) begin
                                ferr_d = 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (perr_q) begin
                                pe_d = 1'b1;
                            end
`endif
                            else begin
                                push_d = 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error = pe_q;
`else
    assign parity_error = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Receive FIFO (show-ahead, pointers carry one wrap bit)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wptr_q, rptr_q;
    logic                 w_empty, w_full, w_pop, w_push;

    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign w_pop   = !w_empty && data_ready;
    // A full FIFO still accepts the byte when a pop frees a slot this cycle.
    assign w_push  = push_q && (!w_full || w_pop);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q[AW-1:0]] <= shreg_q;
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    assign data       = w_empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign data_valid = !w_empty;
    assign fill       = wptr_q - rptr_q;
    assign overflow   = push_q && w_full && !w_pop;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo_param
//  Purpose  : Self-checking bench for uart_rx_fifo_param. Frames are driven
//             at the bit level; expected bytes and error counts come from a
//             frame-level queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo_param;

    localparam int DB    = 8;
    localparam int OS    = 4;
    localparam int DEPTH = 16;
    localparam int PODD  = 0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     baud_tick = 1'b0;
    logic                     serial = 1'b1;
    logic                     data_ready = 1'b0;
    logic [DB-1:0]            data;
    logic                     data_valid;
    logic                     frame_error;
    logic                     parity_error;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fill;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0, perr_cnt = 0, ovf_cnt = 0;
    int exp_ferr = 0, exp_perr = 0, exp_ovf = 0;
    logic [DB-1:0] q[$];

    uart_rx_fifo_param #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH),
        .PARITY_ODD (PODD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_tick    (baud_tick),
        .serial       (serial),
        .data         (data),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .overflow     (overflow),
        .fill         (fill)
    );

    always #5 clk = ~clk;

    // One baud_tick every 4 clocks.
    initial begin : tickgen
        forever begin
            repeat (3) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_error === 1'b1)  ferr_cnt++;
        if (parity_error === 1'b1) perr_cnt++;
        if (overflow === 1'b1)     ovf_cnt++;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input logic [DB-1:0] b);
        return (^b) ^ (PODD != 0);
    endfunction

    // Frame-level reference: outcome of one complete frame.
    function automatic void model_frame(input logic [DB-1:0] b, input logic stop_v,
                                        input logic par_v);
        logic par_ok;
        par_ok = (par_v == good_par(b));
        if (!stop_v)                  exp_ferr++;
        else if (PAR_EN && !par_ok)   exp_perr++;
        else if (q.size() == DEPTH)   exp_ovf++;
        else                          q.push_back(b);
    endfunction

    // Wait for the next clock edge at which baud_tick is sampled high.
    task automatic wait_tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
        #2;
    endtask

    task automatic send_level(input logic v, input int n);
        serial = v;
        repeat (n) wait_tick();
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop_v, input logic par_v,
                              input int rst_bit, input bit pop_on_push);
        send_level(1'b1, 2);
        send_level(1'b0, OS);
        for (int i = 0; i < DB; i++) begin
            if (i == rst_bit) begin
                serial = b[i];
                repeat (2) wait_tick();
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                repeat (OS - 2) wait_tick();
            end else begin
                send_level(b[i], OS);
            end
        end
`ifdef UART_RX_PARITY_EN
        send_level(par_v, OS);
`endif
        send_level(stop_v, OS);
        serial = 1'b1;
        if (pop_on_push) begin
            // Pop lands on the same edge as the push.
            data_ready = 1'b1;
            @(posedge clk);
            #1 data_ready = 1'b0;
            void'(q.pop_front());
        end
        if (rst_bit < 0) model_frame(b, stop_v, par_v);
        else             q.delete();
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
        chk({tag, "_perr"}, perr_cnt, exp_perr);
        chk({tag, "_ovf"},  ovf_cnt,  exp_ovf);
        chk({tag, "_fill"}, fill, q.size());
    endtask

    task automatic pop_n(input string tag, input int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            @(negedge clk);
            chk({tag, "_pop_data"}, data, q[0]);
            data_ready = 1'b1;
            @(negedge clk);
            data_ready = 1'b0;
            void'(q.pop_front());
        end
    endtask

    task automatic drain_check(input string tag);
        @(negedge clk);
        data_ready = 1'b1;
        while (q.size() > 0) begin
            chk({tag, "_drain"}, data, q.pop_front());
            @(negedge clk);
        end
        data_ready = 1'b0;
        chk({tag, "_empty_valid"}, data_valid, 1'b0);
        chk({tag, "_empty_data"}, data, 0);
    endtask

    initial begin : stim
        logic [DB-1:0] rb;
        logic          rs, rp;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_fill", fill, 0);
        chk("rst_data", data, 0);
        chk("rst_errs", {frame_error, parity_error, overflow}, 3'b000);

        // Basic receive
        send_frame(8'h55, 1'b1, good_par(8'h55), -1, 1'b0);
        send_frame(8'hA3, 1'b1, good_par(8'hA3), -1, 1'b0);
        settle();
        chk("basic_fill2", fill, 2);
        chk("basic_head", data, 8'h55);
        chk("basic_valid", data_valid, 1'b1);
        pop_n("basic", 1);
        @(negedge clk);
        chk("basic_after_pop_data", data, 8'hA3);
        chk("basic_after_pop_fill", fill, 1);
        drain_check("basic");

        // Parity: good then wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
        settle();
        chk_counts("parity");
        drain_check("parity");

        // Framing error followed by a good frame
        send_frame(8'h3C, 1'b0, good_par(8'h3C), -1, 1'b0);
        settle();
        chk_counts("frame_bad");
        send_frame(8'h3C, 1'b1, good_par(8'h3C), -1, 1'b0);
        settle();
        chk_counts("frame_good");
        chk("frame_good_data", data, 8'h3C);
        drain_check("frame");

        // Overflow: 17 bytes into 16 entries
        for (int i = 0; i <= 16; i++) begin
            send_frame(DB'(i), 1'b1, good_par(DB'(i)), -1, 1'b0);
        end
        settle();
        chk("ovf_count", ovf_cnt, 1);
        chk("ovf_fill", fill, 16);
        chk_counts("ovf");
        drain_check("ovf");

        // Full FIFO with a pop on the push cycle
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(DB'(8'h40 + i), 1'b1, good_par(DB'(8'h40 + i)), -1, 1'b0);
        end
        settle();
        chk("fullpop_pre_fill", fill, 16);
        send_frame(8'hEE, 1'b1, good_par(8'hEE), -1, 1'b1);
        settle();
        chk("fullpop_fill", fill, 16);
        chk_counts("fullpop");
        drain_check("fullpop");

        // One-tick glitch on idle line
        wait_tick();
        send_level(1'b0, 1);
        send_level(1'b1, 3 * OS);
        settle();
        chk_counts("glitch");

        // Reset during data bit 4, then a clean frame
        send_frame(8'hF0, 1'b1, good_par(8'hF0), 4, 1'b0);
        send_level(1'b1, 2 * OS);
        settle();
        chk_counts("midrst");
        send_frame(8'h81, 1'b1, good_par(8'h81), -1, 1'b0);
        settle();
        chk_counts("midrst_next");
        chk("midrst_next_data", data, 8'h81);
        drain_check("midrst");

        // Randomised frames with occasional errors and pops
        for (int n = 0; n < 24; n++) begin
            rb = DB'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            rp = good_par(rb) ^ ($urandom_range(0, 5) == 0);
            send_frame(rb, rs, rp, -1, 1'b0);
            settle();
            chk_counts("rand");
            if ($urandom_range(0, 2) == 0) pop_n("rand", $urandom_range(1, 3));
        end
        drain_check("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
